if_fetch_ctrl: RTL
==================

# if_fetch_ctrl

Fetch-stage sequencer that owns the architectural PC register and the single instruction-cache port. It sequences boot-time instruction loading into the icache, then runs fetch, applying stall and redirect requests from ID/EX. It drives the icache address and write port and hands PC and PC+4 to the IF/ID register.

## Interface
- `RESET_PC`, default 32'h0000_0000: PC value after reset and after every load completion.
- `IMEM_AW`, default 8: icache word-address width; icache index is `PC[IMEM_AW+1:2]`.
- `in_clk`  in  1  sole clock; all state updates on its rising edge.
- `in_rst`  in  1  reset; synchronous, active-high.
- `in_data_hazard`  in  1  load-use stall; hold PC.
- `in_PCSrc`  in  2  next-PC select: 00 sequential, 01 branch, 10 jump, 11 jr.
- `in_branch_PC_addr`, `in_jump_PC_addr`, `in_jr_PC_addr`  in  32 each  redirect targets.
- `in_boot_req`  in  1  pulse; re-enter load mode.
- `in_ld_valid`  in  1  loader word valid.
- `in_ld_addr`  in  IMEM_AW  loader word address.
- `in_ld_data`  in  32  loader instruction word.
- `in_ld_done`  in  1  loader finished.
- `out_ld_ready`  out  1  controller accepts loader words.
- `out_icache_addr`  out  IMEM_AW  icache address, read and write.
- `out_icache_we`  out  1  icache write enable.
- `out_icache_wdata`  out  32  icache write data.
- `out_PC`  out  32  PC of the instruction being fetched.
- `out_PC_plus4`  out  32  `out_PC + 4`, modulo 2^32.
- `out_fetch_valid`  out  1  fetched word is a real instruction.
- `out_misalign`  out  1  sticky: a redirect target had nonzero bits [1:0].
- `out_ld_count`  out  IMEM_AW+1  accepted loader words, saturating at 2^IMEM_AW.
- `out_state`  out  2  LOAD=00, FLUSH=01, RUN=10.

## Operation
- **States:**
  - LOAD: `out_ld_ready`=1. Each `in_ld_valid` cycle writes `in_ld_data` to `in_ld_addr` (`out_icache_we`=1) and increments `out_ld_count`.
  - FLUSH: one cycle. PC←`RESET_PC`; `out_fetch_valid`=0.
  - RUN: normal fetch.
- **Transitions:**
  - LOAD→FLUSH on `in_ld_done`. If `in_ld_valid` is also high that cycle, the write is performed first.
  - FLUSH→RUN unconditionally.
  - RUN→LOAD on `in_boot_req`. `out_ld_count` clears on entry to LOAD.
- **RUN next-PC priority:**
  1. `in_data_hazard`: PC holds.
  2. `in_PCSrc` = 01/10/11: PC ← selected target with bits [1:0] forced to 0. `out_misalign` is set if the raw target bits [1:0] ≠ 0.
  3. Otherwise PC ← PC+4.
- **Stall vs redirect:** when `in_data_hazard` and a nonzero `in_PCSrc` are both high, the stall wins and the redirect is dropped. ID must re-present the redirect.
- **Boot request vs stall/redirect:** `in_boot_req` in RUN overrides both.
- **Address and valid:**
  - `out_icache_addr` = `in_ld_addr` in LOAD, else `PC[IMEM_AW+1:2]`. PC above the icache span aliases (wraps).
  - `out_fetch_valid` = 1 only in RUN. It is 0 in the cycle after `in_boot_req` is sampled.
- **Arithmetic:** PC+4 wraps at 32'hFFFF_FFFC → 32'h0000_0000.
- **Count:** `out_ld_count` saturates and does not wrap.
- **Out-of-state loader inputs:** `in_ld_valid`/`in_ld_done` outside LOAD are ignored.

## Timing
- **Reset values:**
  - State = LOAD (FLUSH when the boot load is compiled out).
  - PC = `RESET_PC`.
  - `out_misalign`=0, `out_ld_count`=0, `out_icache_we`=0.
  - `out_fetch_valid`=0.
  - `out_ld_ready`=1 with the boot load compiled in, else 0.
- **Reset mid-operation:** reset in any state aborts it; a partial load is not resumed.
- **Registered vs combinational:**
  - `out_PC` and the state are registered.
  - `out_PC_plus4`, `out_icache_addr`/`we`/`wdata`, `out_ld_ready` and `out_fetch_valid` are combinational from state/PC/loader inputs.
  - The icache read is asynchronous, so the instruction is available in the same cycle as `out_PC`.
- **Latencies:**
  - A redirect sampled at edge N appears on `out_PC` after edge N.
  - `in_ld_done` at edge N → FLUSH during cycle N+1 → first valid fetch at `RESET_PC` in cycle N+2.
- **Loader handshake:** a word transfers when `in_ld_valid` && `out_ld_ready`. There is no backpressure inside LOAD.

## Configuration
- `IF_FETCH_BOOT_LOAD_EN` defined:
  - LOAD state, the loader ports and `out_ld_count` are functional.
  - `in_boot_req` is honored.
- Not defined:
  - Reset enters FLUSH directly.
  - `out_ld_ready`=0, `out_icache_we`=0, `out_ld_count`=0.
  - `in_boot_req` and the loader inputs are ignored; the icache is assumed preloaded by its init file.

## Structure
- Shared package `if_pkg`:
  - State encodings (LOAD/FLUSH/RUN).
  - PCSrc encodings (`PCSRC_SEQ`/`BR`/`J`/`JR`).
  - Default `RESET_PC`.
- Sub-module `if_next_pc`: combinational priority mux plus alignment/misalign detect. The state machine, PC register and counter stay in the top.

## Test plan
- **Reset and boot load:** reset; load addr 0..3 with 32'h2001_0005.. words, then `in_ld_done` → `out_ld_count`=4; FLUSH for one cycle; RUN fetch at PC 0, 4, 8 with `out_fetch_valid`=1.
- **Stall:** in RUN at PC=0x10, `in_data_hazard` held 2 cycles → `out_PC` stays 0x10, then 0x14.
- **Priority and alignment:** `in_PCSrc`=11, `in_jr_PC_addr`=0x42 → next PC 0x40 and `out_misalign`=1 (sticky). The same redirect with `in_data_hazard`=1 → PC holds.
- **Wrap-around:**
  - PC=0xFFFF_FFFC sequential → 0x0000_0000.
  - PC=0x400 with `IMEM_AW`=8 → `out_icache_addr`=0.
- **Re-boot and final-word write:** `in_boot_req` in RUN → next cycle LOAD with `out_fetch_valid`=0 and count cleared. `in_ld_valid`+`in_ld_done` in the same cycle → the word is written, then FLUSH.
- **Macro undefined:** reset → FLUSH then RUN at `RESET_PC`; loader pulses produce `out_icache_we`=0.

Source files
------------

// File: rtl/if_pkg.sv
// if_pkg: shared state/PC-select encodings and defaults for the fetch controller
package if_pkg;
  typedef enum logic [1:0] {
    ST_LOAD  = 2'b00,
    ST_FLUSH = 2'b01,
    ST_RUN   = 2'b10
  } if_state_e;
  localparam logic [1:0] PCSRC_SEQ = 2'b00;
  localparam logic [1:0] PCSRC_BR  = 2'b01;
  localparam logic [1:0] PCSRC_J   = 2'b10;
  localparam logic [1:0] PCSRC_JR  = 2'b11;
  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;
  function automatic logic [31:0] align_word(input logic [31:0] a);
    return {a[31:2], 2'b00};
  endfunction
endpackage

// File: rtl/if_next_pc.sv
// if_next_pc: next-PC priority mux (hold > redirect > sequential) with misalign detect
// Ports: pc_i current PC; hold_i stall; pcsrc_i select; branch_i/jump_i/jr_i targets;
//        next_pc_o chosen PC; pc_plus4_o PC+4 (wraps); misalign_o taken redirect had target[1:0]!=0
module if_next_pc
  import if_pkg::*;
(
  input  logic [31:0] pc_i,
  input  logic        hold_i,
  input  logic [1:0]  pcsrc_i,
  input  logic [31:0] branch_i,
  input  logic [31:0] jump_i,
  input  logic [31:0] jr_i,
  output logic [31:0] next_pc_o,
  output logic [31:0] pc_plus4_o,
  output logic        misalign_o
);
  logic [31:0] tgt;
  always_comb begin
    tgt = pcsrc_i == PCSRC_BR ? branch_i : pcsrc_i == PCSRC_J ? jump_i : jr_i;
    pc_plus4_o = pc_i + 32'd4;
    next_pc_o = hold_i ? pc_i : pcsrc_i == PCSRC_SEQ ? pc_plus4_o : align_word(tgt);
    // a stalled redirect is dropped, so it must not flag misalignment either
    misalign_o = !hold_i && pcsrc_i != PCSRC_SEQ && |tgt[1:0];
  end
endmodule

// File: rtl/if_fetch_ctrl.sv
// if_fetch_ctrl: fetch sequencer owning the PC and the single icache port (boot load, flush, run)
// Ports: in_clk/in_rst clock and sync active-high reset; in_data_hazard stall; in_PCSrc and
//        in_*_PC_addr redirects; in_boot_req re-enter load; in_ld_* loader stream; out_ld_ready;
//        out_icache_addr/we/wdata icache port; out_PC/out_PC_plus4 to IF/ID; out_fetch_valid;
//        out_misalign sticky; out_ld_count saturating word count; out_state LOAD/FLUSH/RUN.
// Build option: IF_FETCH_BOOT_LOAD_EN enables the boot loader; without it reset goes to FLUSH.
module if_fetch_ctrl
  import if_pkg::*;
#(
  parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC,
  parameter int          IMEM_AW  = 8
) (
  input  logic               in_clk,
  input  logic               in_rst,
  input  logic               in_data_hazard,
  input  logic [1:0]         in_PCSrc,
  input  logic [31:0]        in_branch_PC_addr,
  input  logic [31:0]        in_jump_PC_addr,
  input  logic [31:0]        in_jr_PC_addr,
  input  logic               in_boot_req,
  input  logic               in_ld_valid,
  input  logic [IMEM_AW-1:0] in_ld_addr,
  input  logic [31:0]        in_ld_data,
  input  logic               in_ld_done,
  output logic               out_ld_ready,
  output logic [IMEM_AW-1:0] out_icache_addr,
  output logic               out_icache_we,
  output logic [31:0]        out_icache_wdata,
  output logic [31:0]        out_PC,
  output logic [31:0]        out_PC_plus4,
  output logic               out_fetch_valid,
  output logic               out_misalign,
  output logic [IMEM_AW:0]   out_ld_count,
  output logic [1:0]         out_state
);
`ifdef IF_FETCH_BOOT_LOAD_EN
  localparam logic BOOT_EN = 1'b1;
`else
  localparam logic BOOT_EN = 1'b0;
`endif
  localparam if_state_e RST_STATE = BOOT_EN ? ST_LOAD : ST_FLUSH;
  localparam logic [IMEM_AW:0] CNT_MAX = {1'b1, {IMEM_AW{1'b0}}};
  if_state_e state_q, state_d;
  logic [31:0] pc_q, pc_d, npc, pc4;
  logic mis_q, mis_d, redir_mis, is_load;
  logic [IMEM_AW:0] cnt_q, cnt_d;
  if_next_pc u_next_pc (
    .pc_i      (pc_q),
    .hold_i    (in_data_hazard),
    .pcsrc_i   (in_PCSrc),
    .branch_i  (in_branch_PC_addr),
    .jump_i    (in_jump_PC_addr),
    .jr_i      (in_jr_PC_addr),
    .next_pc_o (npc),
    .pc_plus4_o(pc4),
    .misalign_o(redir_mis)
  );
  always_comb begin
    state_d = state_q;
    pc_d = pc_q;
    mis_d = mis_q;
    cnt_d = cnt_q;
    case (state_q)
      ST_LOAD: begin
        if (in_ld_valid && cnt_q != CNT_MAX) cnt_d = cnt_q + (IMEM_AW+1)'(1);
        // a word presented together with done is still written this cycle
        if (in_ld_done) state_d = ST_FLUSH;
      end
      ST_FLUSH: begin
        pc_d = RESET_PC;
        state_d = ST_RUN;
      end
      ST_RUN: begin
        // boot request outranks both stall and redirect; PC is reloaded by the following FLUSH
        if (BOOT_EN && in_boot_req) begin
          state_d = ST_LOAD;
          cnt_d = '0;
        end else begin
          pc_d = npc;
          mis_d = mis_q | redir_mis;
        end
      end
      default: state_d = RST_STATE;
    endcase
  end
  always_ff @(posedge in_clk) begin
    if (in_rst) begin
      state_q <= RST_STATE;
      pc_q <= RESET_PC;
      mis_q <= 1'b0;
      cnt_q <= '0;
    end else begin
      state_q <= state_d;
      pc_q <= pc_d;
      mis_q <= mis_d;
      cnt_q <= cnt_d;
    end
  end
  always_comb begin
    is_load = BOOT_EN && state_q == ST_LOAD;
    out_ld_ready = is_load;
    out_icache_we = is_load && in_ld_valid;
    out_icache_wdata = is_load ? in_ld_data : '0;
    // PCs beyond the icache span alias onto it
    out_icache_addr = is_load ? in_ld_addr : pc_q[IMEM_AW+1:2];
    out_PC = pc_q;
    out_PC_plus4 = pc4;
    out_fetch_valid = state_q == ST_RUN;
    out_misalign = mis_q;
    out_ld_count = cnt_q;
    out_state = state_q;
  end
endmodule
